pacman_input_ctrl: RTL and testbench

Downstream consumer of the SoC's `keycode_export` PIO in the PACMAN design. Filters the 8-bit USB HID keycode written by NIOS software and turns key presses into game commands. Buffers requested turns in a small queue that the movement engine drains through a valid/ready handshake. Also generates pause toggling and a hold-to-restart pulse timed in video frames.

---
 rtl/pacman_input_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_pacman_input_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pacman_input_ctrl.sv
// Keyboard front end for PACMAN: debounces the NIOS keycode, queues requested turns
// for the movement engine, toggles pause and produces a hold-R-to-restart pulse.
module pacman_input_ctrl #(
    parameter int STABLE_CYCLES = 4,
    parameter int QDEPTH        = 2,
    parameter int HOLD_FRAMES   = 30
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [7:0] keycode,
    input  logic       frame_tick,
    input  logic       dir_ready,
    output logic       dir_valid,
    output logic [1:0] dir_data,
    output logic [1:0] cur_dir,
    output logic       paused,
    output logic       restart
);

    localparam logic [7:0] STABLE_SAT = 8'(STABLE_CYCLES);
    localparam logic [7:0] HOLD_LAST  = 8'(HOLD_FRAMES - 1);
    localparam logic [2:0] Q_FULL     = 3'(QDEPTH);
    localparam logic [1:0] PTR_LAST   = 2'(QDEPTH - 1);
    localparam logic [7:0] KEY_P      = 8'h13;
    localparam logic [7:0] KEY_R      = 8'h15;
    localparam logic [1:0] DIR_LEFT   = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_HOLD,
        S_FIRE,
        S_WAITREL
    } rst_state_t;

    function automatic logic [2:0] dir_of(input logic [7:0] code);
        case (code)
            8'h1A, 8'h52: return 3'b1_00;
            8'h16, 8'h51: return 3'b1_01;
            8'h04, 8'h50: return 3'b1_10;
            8'h07, 8'h4F: return 3'b1_11;
            default:      return 3'b0_00;
        endcase
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] cnt);
        return (cnt == STABLE_SAT) ? cnt : cnt + 8'd1;
    endfunction

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == PTR_LAST) ? 2'd0 : p + 2'd1;
    endfunction

    function automatic logic [1:0] ptr_dec(input logic [1:0] p);
        return (p == 2'd0) ? PTR_LAST : p - 2'd1;
    endfunction

    logic [7:0] k_q;
    logic [7:0] k_stable;
    logic [7:0] stab_cnt;
    logic       k_load;
    logic       press_ev;

    // Key filter: register raw code, accept it after STABLE_CYCLES unchanged cycles
    always_ff @(posedge Clk) begin
        if (Reset) begin
            k_q      <= 8'h00;
            k_stable <= 8'h00;
            stab_cnt <= 8'h00;
        end else begin
            k_q      <= keycode;
            stab_cnt <= (keycode != k_q) ? 8'h00 : sat_inc(stab_cnt);
            if (k_load)
                k_stable <= k_q;
        end
    end

    assign k_load   = (stab_cnt == STABLE_SAT);
    assign press_ev = k_load && (k_q != k_stable) && (k_q != 8'h00);

    logic [1:0] q_mem [4];
    logic [1:0] rd_ptr;
    logic [1:0] wr_ptr;
    logic [2:0] q_count;
    logic       is_dir;
    logic [1:0] press_dir;
    logic [1:0] tail_dir;
    logic       q_empty;
    logic       pop;
    logic       push_req;
    logic       overwrite;
    logic       append;
    logic       pause_tog;
    logic       flush;
    logic       fire;

    rst_state_t state;
    rst_state_t state_nxt;
    logic [7:0] frame_cnt;

    always_comb begin
        {is_dir, press_dir} = dir_of(k_q);
        tail_dir  = q_mem[ptr_dec(wr_ptr)];
        q_empty   = (q_count == 3'd0);
        pop       = dir_valid && dir_ready;
        // Duplicate checks use the pre-pop tail and pre-pop emptiness
        push_req  = press_ev && is_dir && !paused
                    && !(!q_empty && (press_dir == tail_dir))
                    && !(q_empty && (press_dir == cur_dir));
        overwrite = push_req && (q_count == Q_FULL) && !pop;
        append    = push_req && !overwrite;
        pause_tog = press_ev && (k_q == KEY_P);
        fire      = (state == S_FIRE);
        flush     = (pause_tog && !paused) || fire;
    end

    // Turn queue, current direction and pause state
    always_ff @(posedge Clk) begin
        if (Reset) begin
            rd_ptr  <= 2'd0;
            wr_ptr  <= 2'd0;
            q_count <= 3'd0;
            cur_dir <= DIR_LEFT;
            paused  <= 1'b0;
        end else begin
            if (pop)
                cur_dir <= q_mem[rd_ptr];
            if (flush) begin
                rd_ptr  <= 2'd0;
                wr_ptr  <= 2'd0;
                q_count <= 3'd0;
            end else begin
                if (pop)
                    rd_ptr <= ptr_inc(rd_ptr);
                if (append)
                    wr_ptr <= ptr_inc(wr_ptr);
                q_count <= q_count + {2'b00, append} - {2'b00, pop};
            end
            if (pause_tog)
                paused <= !paused;
            if (fire) begin
                paused  <= 1'b0;
                cur_dir <= DIR_LEFT;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (append)
            q_mem[wr_ptr] <= press_dir;
        else if (overwrite)
            q_mem[ptr_dec(wr_ptr)] <= press_dir;
    end

    assign dir_valid = !q_empty && !paused;
    assign dir_data  = q_empty ? 2'b00 : q_mem[rd_ptr];

    // Restart FSM: frames are counted only while R stays accepted
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= S_IDLE;
            frame_cnt <= 8'h00;
        end else begin
            state <= state_nxt;
            if (state != S_HOLD)
                frame_cnt <= 8'h00;
            else if (frame_tick)
                frame_cnt <= frame_cnt + 8'd1;
        end
    end

    always_comb begin
        state_nxt = state;
        restart   = 1'b0;
        case (state)
            S_IDLE: begin
                if (press_ev && (k_q == KEY_R))
                    state_nxt = S_HOLD;
            end
            S_HOLD: begin
                if (k_stable != KEY_R)
                    state_nxt = S_IDLE;
                else if (frame_tick && (frame_cnt == HOLD_LAST))
                    state_nxt = S_FIRE;
            end
            S_FIRE: begin
                restart   = 1'b1;
                state_nxt = S_WAITREL;
            end
            S_WAITREL: begin
                if (k_stable != KEY_R)
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_pacman_input_ctrl.sv
// Bench for pacman_input_ctrl: directed scenarios plus random key traffic, scored
// against a window-based reference model through transfer/restart queues.
module tb_pacman_input_ctrl;

    localparam int S  = 4;
    localparam int QD = 2;
    localparam int HF = 30;

    logic       Clk = 1'b0;
    logic       Reset;
    logic [7:0] keycode;
    logic       frame_tick;
    logic       dir_ready;
    logic       dir_valid;
    logic [1:0] dir_data;
    logic [1:0] cur_dir;
    logic       paused;
    logic       restart;

    always #10 Clk = ~Clk;

    pacman_input_ctrl #(.STABLE_CYCLES(S), .QDEPTH(QD), .HOLD_FRAMES(HF)) dut (
        .Clk(Clk), .Reset(Reset), .keycode(keycode), .frame_tick(frame_tick),
        .dir_ready(dir_ready), .dir_valid(dir_valid), .dir_data(dir_data),
        .cur_dir(cur_dir), .paused(paused), .restart(restart)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    typedef struct {
        logic [1:0] d;
        int         cyc;
    } xfer_t;
    xfer_t dq[$];
    int    rq[$];

    // Reference model state
    logic [7:0] hist[$];
    logic [7:0] m_stable;
    logic [1:0] mq[$];
    logic [1:0] m_cur;
    bit         m_paused, m_fire, m_holding, m_waitrel, m_init = 0;
    int         m_ticks;
    logic [6:0] e_vec;
    bit         e_ok = 0;

    function automatic logic [2:0] dir_of(input logic [7:0] c);
        case (c)
            8'h1A, 8'h52: return 3'b100;
            8'h16, 8'h51: return 3'b101;
            8'h04, 8'h50: return 3'b110;
            8'h07, 8'h4F: return 3'b111;
            default:      return 3'b000;
        endcase
    endfunction

    // Model: a key is accepted when the last S+1 sampled codes agree
    always @(negedge Clk) begin : model_step
        bit         all_eq, ev, pop, e_valid, drop, fire_next;
        logic [7:0] v;
        logic [2:0] dd;
        logic [1:0] e_data;
        cyc++;
        e_ok = m_init;
        if (m_init) begin
            e_valid = (mq.size() != 0) && !m_paused;
            e_data  = (mq.size() != 0) ? mq[0] : 2'b00;
            e_vec   = {e_valid, e_data, m_cur, m_paused, m_fire};
            if (e_valid && dir_ready === 1'b1)
                dq.push_back('{d: mq[0], cyc: cyc});
            if (m_fire)
                rq.push_back(cyc);
        end
        if (Reset === 1'b1) begin
            hist.delete();
            hist.push_back(8'h00);
            mq.delete();
            m_stable  = 8'h00;
            m_cur     = 2'b10;
            m_paused  = 0;
            m_fire    = 0;
            m_holding = 0;
            m_waitrel = 0;
            m_ticks   = 0;
            m_init    = 1;
        end else if (m_init) begin
            all_eq = (hist.size() == S + 1);
            v      = hist[0];
            foreach (hist[i]) if (hist[i] != v) all_eq = 0;
            ev  = all_eq && (v != m_stable) && (v != 8'h00);
            pop = e_valid && (dir_ready === 1'b1);
            dd  = dir_of(v);
            drop = 1;
            if (ev && dd[2])
                drop = m_paused || ((mq.size() != 0) && dd[1:0] == mq[mq.size()-1])
                       || ((mq.size() == 0) && dd[1:0] == m_cur);
            if (pop)
                m_cur = mq.pop_front();
            if (!drop) begin
                if (mq.size() == QD) mq[mq.size()-1] = dd[1:0];
                else                 mq.push_back(dd[1:0]);
            end
            if (ev && v == 8'h13) begin
                m_paused = !m_paused;
                if (m_paused) mq.delete();
            end
            fire_next = 0;
            if (m_fire) begin
                mq.delete();
                m_paused  = 0;
                m_cur     = 2'b10;
                m_waitrel = 1;
            end else if (m_holding) begin
                if (m_stable != 8'h15) m_holding = 0;
                else if (frame_tick === 1'b1) begin
                    m_ticks++;
                    if (m_ticks == HF) begin
                        m_holding = 0;
                        fire_next = 1;
                    end
                end
            end else if (m_waitrel) begin
                if (m_stable != 8'h15) m_waitrel = 0;
            end else if (ev && v == 8'h15) begin
                m_holding = 1;
                m_ticks   = 0;
            end
            m_fire = fire_next;
            if (all_eq) m_stable = v;
            hist.push_back(keycode);
            if (hist.size() > S + 1) void'(hist.pop_front());
        end
    end

    always @(negedge Clk) begin : monitor
        xfer_t x;
        int    rc;
        #1;
        if (e_ok) begin
            n_cmp++;
            if ({dir_valid, dir_data, cur_dir, paused, restart} !== e_vec) begin
                n_fail++;
                $display("FAIL state cyc=%0d got v=%b d=%b cur=%b p=%b r=%b want {v,d,cur,p,r}=%b",
                         cyc, dir_valid, dir_data, cur_dir, paused, restart, e_vec);
            end
            if (dir_valid === 1'b1 && dir_ready === 1'b1) begin
                n_cmp++;
                if (dq.size() == 0) begin
                    n_fail++;
                    $display("FAIL xfer cyc=%0d got d=%b want no transfer", cyc, dir_data);
                end else begin
                    x = dq.pop_front();
                    if (x.d !== dir_data || x.cyc != cyc) begin
                        n_fail++;
                        $display("FAIL xfer got d=%b cyc=%0d want d=%b cyc=%0d", dir_data, cyc, x.d, x.cyc);
                    end
                end
            end
            if (restart === 1'b1) begin
                n_cmp++;
                if (rq.size() == 0) begin
                    n_fail++;
                    $display("FAIL restart_evt cyc=%0d got pulse want none", cyc);
                end else begin
                    rc = rq.pop_front();
                    if (rc != cyc) begin
                        n_fail++;
                        $display("FAIL restart_evt got cyc=%0d want cyc=%0d", cyc, rc);
                    end
                end
            end
        end
    end

    task automatic tick_n(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%0h want=%0h", nm, got, want);
        end
    endtask

    task automatic key(input logic [7:0] c, input int n);
        keycode = c;
        tick_n(n);
    endtask

    task automatic frames(input int nf, output int pulses);
        pulses = 0;
        for (int i = 0; i < nf * 4; i++) begin
            frame_tick = (i % 4 == 0);
            tick_n(1);
            if (restart === 1'b1) pulses++;
        end
        frame_tick = 1'b0;
    endtask

    logic [7:0] codes [10] = '{8'h1A, 8'h52, 8'h16, 8'h51, 8'h04, 8'h50, 8'h07, 8'h4F, 8'h13, 8'h15};

    initial begin
        int         np;
        int         r, len;
        logic [7:0] code, prev;
        Reset = 1'b1; keycode = 8'h00; frame_tick = 1'b0; dir_ready = 1'b0;
        tick_n(3);
        Reset = 1'b0;
        tick_n(1);
        chk("rst_valid", {7'd0, dir_valid}, 8'h00);
        chk("rst_data", {6'd0, dir_data}, 8'h00);
        chk("rst_cur", {6'd0, cur_dir}, 8'h02);
        chk("rst_paused", {7'd0, paused}, 8'h00);
        chk("rst_restart", {7'd0, restart}, 8'h00);

        keycode = 8'h1A;
        tick_n(S + 1);
        chk("w_early_valid", {7'd0, dir_valid}, 8'h00);
        tick_n(1);
        chk("w_valid", {7'd0, dir_valid}, 8'h01);
        chk("w_data", {6'd0, dir_data}, 8'h00);
        dir_ready = 1'b1;
        tick_n(1);
        dir_ready = 1'b0;
        chk("w_pop_cur", {6'd0, cur_dir}, 8'h00);
        chk("w_pop_valid", {7'd0, dir_valid}, 8'h00);

        key(8'h07, 3); key(8'h00, 8);
        chk("glitch_valid", {7'd0, dir_valid}, 8'h00);
        key(8'h04, 8); key(8'h00, 8); key(8'h16, 8); key(8'h00, 8); key(8'h07, 8);
        chk("ovr_head", {5'd0, dir_valid, dir_data}, 8'h06);
        dir_ready = 1'b1;
        tick_n(1);
        chk("ovr_pop1_cur", {6'd0, cur_dir}, 8'h02);
        chk("ovr_pop1_next", {6'd0, dir_data}, 8'h03);
        tick_n(1);
        dir_ready = 1'b0;
        chk("ovr_pop2", {5'd0, dir_valid, cur_dir}, 8'h03);

        key(8'h00, 8); key(8'h04, 8); key(8'h00, 8); key(8'h16, 8); key(8'h00, 8);
        keycode = 8'h4F;
        tick_n(S + 1);
        dir_ready = 1'b1;
        tick_n(1);
        dir_ready = 1'b0;
        chk("sim_cur", {6'd0, cur_dir}, 8'h02);
        chk("sim_head", {5'd0, dir_valid, dir_data}, 8'h05);
        dir_ready = 1'b1;
        tick_n(1);
        chk("sim_second", {6'd0, dir_data}, 8'h03);
        tick_n(1);
        dir_ready = 1'b0;
        chk("sim_drained", {5'd0, dir_valid, cur_dir}, 8'h03);

        key(8'h00, 8); key(8'h1A, 8);
        chk("pause_pre", {5'd0, dir_valid, dir_data}, 8'h04);
        key(8'h00, 8); key(8'h13, 8);
        chk("pause_on", {6'd0, paused, dir_valid}, 8'h02);
        key(8'h00, 8); key(8'h1A, 8); key(8'h00, 8); key(8'h13, 8);
        chk("pause_off", {6'd0, paused, dir_valid}, 8'h00);
        key(8'h00, 8);

        keycode = 8'h15;
        frames(35, np);
        chk("restart_once", 8'(np), 8'h01);
        chk("restart_cur", {6'd0, cur_dir}, 8'h02);
        chk("restart_paused", {7'd0, paused}, 8'h00);
        frames(100, np);
        chk("restart_held", 8'(np), 8'h00);
        key(8'h00, 10);
        key(8'h15, 8);
        frames(29, np);
        keycode = 8'h00;
        for (int i = 0; i < 20; i++) begin
            tick_n(1);
            if (restart === 1'b1) np++;
        end
        chk("restart_early_rel", 8'(np), 8'h00);

        key(8'h07, 8);
        chk("midhold_q", {5'd0, dir_valid, dir_data}, 8'h07);
        key(8'h00, 8); key(8'h15, 8);
        frames(5, np);
        Reset = 1'b1; keycode = 8'h00;
        tick_n(1);
        Reset = 1'b0;
        chk("midhold_rst", {dir_valid, dir_data, cur_dir, paused, restart}, 8'h08);

        prev = 8'h00;
        for (int seg = 0; seg < 450; seg++) begin
            r = $urandom_range(0, 11);
            len = $urandom_range(1, 12);
            if (r < 2)       code = 8'h00;
            else if (r < 10) code = codes[$urandom_range(0, 9)];
            else if (r == 10) code = 8'($urandom);
            else begin
                code = codes[$urandom_range(0, 7)];
                len = $urandom_range(1, S - 1);
            end
            if (code == 8'h15 && $urandom_range(0, 2) == 0) len = 150;
            for (int c = 0; c < len; c++) begin
                keycode    = code;
                dir_ready  = ($urandom_range(0, 1) == 1);
                frame_tick = ($urandom_range(0, 3) == 0);
                Reset      = ($urandom_range(0, 999) == 0);
                tick_n(1);
            end
            Reset = 1'b0;
            if (r == 11) begin
                keycode = prev;
                tick_n(6);
            end else begin
                prev = code;
            end
        end
        keycode = 8'h00; frame_tick = 1'b0; dir_ready = 1'b1;
        tick_n(20);
        n_cmp++;
        if (dq.size() != 0 || rq.size() != 0) begin
            n_fail++;
            $display("FAIL leftover got xfers=%0d restarts=%0d want 0 and 0", dq.size(), rq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
